// File: rtl/register_decimal_pkg.sv
// Shared types and moduli for the two-digit BCD time registers.
// Optional borrow output enabled by REGISTER_DECIMAL_BORROW_EN.
package register_decimal_pkg;

  typedef logic [3:0] bcd_t;

  localparam int MOD_HOURS  = 24;
  localparam int MOD_MINSEC = 60;

  function automatic bcd_t tens(input int v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t units(input int v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/register_decimal_if.sv
// Control/digit bundle for one BCD register; master drives the steps.
// Carries bout only when REGISTER_DECIMAL_BORROW_EN is defined.
interface register_decimal_if (
  input logic clk
);
  import register_decimal_pkg::*;

  logic add;
  logic sub;
  logic hold;
  bcd_t low;
  bcd_t high;
  logic cout;
`ifdef REGISTER_DECIMAL_BORROW_EN
  logic bout;
`endif

  modport master (
    input  clk,
    output add, sub, hold,
    input  low, high, cout
`ifdef REGISTER_DECIMAL_BORROW_EN
    , input bout
`endif
  );

  modport slave (
    input  clk,
    input  add, sub, hold,
    output low, high, cout
`ifdef REGISTER_DECIMAL_BORROW_EN
    , output bout
`endif
  );

endinterface

// File: rtl/register_decimal_wrappers.sv
// Fixed-modulus wrappers: hours (24) and minutes/seconds (60).
// bout port present only with REGISTER_DECIMAL_BORROW_EN.
module register24_decimal
  import register_decimal_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic add,
  input  logic sub,
  input  logic hold,
  output bcd_t low,
  output bcd_t high,
  output logic cout
`ifdef REGISTER_DECIMAL_BORROW_EN
  , output logic bout
`endif
);

  register_decimal #(
    .MODULUS(MOD_HOURS)
  ) u_reg (
    .clk  (clk),
    .rst  (rst),
    .add  (add),
    .sub  (sub),
    .hold (hold),
    .low  (low),
    .high (high),
    .cout (cout)
`ifdef REGISTER_DECIMAL_BORROW_EN
    , .bout (bout)
`endif
  );

endmodule

module register60_decimal
  import register_decimal_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic add,
  input  logic sub,
  input  logic hold,
  output bcd_t low,
  output bcd_t high,
  output logic cout
`ifdef REGISTER_DECIMAL_BORROW_EN
  , output logic bout
`endif
);

  register_decimal #(
    .MODULUS(MOD_MINSEC)
  ) u_reg (
    .clk  (clk),
    .rst  (rst),
    .add  (add),
    .sub  (sub),
    .hold (hold),
    .low  (low),
    .high (high),
    .cout (cout)
`ifdef REGISTER_DECIMAL_BORROW_EN
    , .bout (bout)
`endif
  );

endmodule

// File: rtl/register_decimal.sv
// Two-digit BCD up/down counter, modulo MODULUS, cascadable via cout.
// Optional borrow output enabled by REGISTER_DECIMAL_BORROW_EN.
module register_decimal
  import register_decimal_pkg::*;
#(
  parameter int MODULUS = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic add,
  input  logic sub,
  input  logic hold,
  output bcd_t low,
  output bcd_t high,
  output logic cout
`ifdef REGISTER_DECIMAL_BORROW_EN
  , output logic bout
`endif
);

  localparam bcd_t MAX_HI = tens(MODULUS - 1);
  localparam bcd_t MAX_LO = units(MODULUS - 1);

  generate
    if (MODULUS < 2 || MODULUS > 99) begin : g_bad_mod
      $error("register_decimal: MODULUS must be 2..99");
    end
  endgenerate

  // Initializers give a defined count before the first reset.
  bcd_t low_q  = '0;
  bcd_t high_q = '0;
  bcd_t low_d;
  bcd_t high_d;

  logic inc;
  logic dec;
  logic at_max;
  logic at_zero;

  always_comb begin
    inc     = add & ~sub & ~hold;
    dec     = sub & ~add & ~hold;
    at_max  = (high_q == MAX_HI) && (low_q == MAX_LO);
    at_zero = (high_q == 4'd0) && (low_q == 4'd0);
    low_d   = low_q;
    high_d  = high_q;
    if (inc) begin
      if (at_max) begin
        low_d  = 4'd0;
        high_d = 4'd0;
      end else if (low_q == 4'd9) begin
        low_d  = 4'd0;
        high_d = high_q + 4'd1;
      end else begin
        low_d  = low_q + 4'd1;
      end
    end else if (dec) begin
      if (at_zero) begin
        low_d  = MAX_LO;
        high_d = MAX_HI;
      end else if (low_q == 4'd0) begin
        low_d  = 4'd9;
        high_d = high_q - 4'd1;
      end else begin
        low_d  = low_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      low_q  <= 4'd0;
      high_q <= 4'd0;
    end else begin
      low_q  <= low_d;
      high_q <= high_d;
    end
  end

  assign low  = low_q;
  assign high = high_q;
  // Carry is combinational so the next stage steps on the same edge.
  assign cout = inc & rst & at_max;
`ifdef REGISTER_DECIMAL_BORROW_EN
  assign bout = dec & rst & at_zero;
`endif

endmodule

// File: tb/tb_register_decimal.sv
// Scoreboard bench: mod-60, mod-24 and a sec/min/hr cascade vs model.
// Borrow checks active when REGISTER_DECIMAL_BORROW_EN is defined.
module tb_register_decimal;
  import register_decimal_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic ca  = 1'b0;
  logic cs  = 1'b0;

  register_decimal_if bus60 (clk);
  register_decimal_if bus24 (clk);

  bcd_t s_lo, s_hi, m_lo, m_hi, h_lo, h_hi;
  logic s_co, m_co, h_co;
`ifdef REGISTER_DECIMAL_BORROW_EN
  logic s_bo, m_bo, h_bo;
`endif

  register_decimal #(.MODULUS(60)) dut60 (
    .clk  (clk),
    .rst  (rst),
    .add  (bus60.add),
    .sub  (bus60.sub),
    .hold (bus60.hold),
    .low  (bus60.low),
    .high (bus60.high),
    .cout (bus60.cout)
`ifdef REGISTER_DECIMAL_BORROW_EN
    , .bout (bus60.bout)
`endif
  );

  register24_decimal dut24 (
    .clk  (clk),
    .rst  (rst),
    .add  (bus24.add),
    .sub  (bus24.sub),
    .hold (bus24.hold),
    .low  (bus24.low),
    .high (bus24.high),
    .cout (bus24.cout)
`ifdef REGISTER_DECIMAL_BORROW_EN
    , .bout (bus24.bout)
`endif
  );

  register60_decimal u_sec (
    .clk (clk), .rst (rst), .add (ca), .sub (cs),
    .hold (1'b0), .low (s_lo), .high (s_hi), .cout (s_co)
`ifdef REGISTER_DECIMAL_BORROW_EN
    , .bout (s_bo)
`endif
  );

  register60_decimal u_min (
    .clk (clk), .rst (rst), .add (s_co), .sub (cs),
    .hold (1'b0), .low (m_lo), .high (m_hi), .cout (m_co)
`ifdef REGISTER_DECIMAL_BORROW_EN
    , .bout (m_bo)
`endif
  );

  register24_decimal u_hr (
    .clk (clk), .rst (rst), .add (m_co), .sub (cs),
    .hold (1'b0), .low (h_lo), .high (h_hi), .cout (h_co)
`ifdef REGISTER_DECIMAL_BORROW_EN
    , .bout (h_bo)
`endif
  );

  typedef struct {
    int   v60;
    int   v24;
    logic c60;
    logic c24;
    logic b60;
    logic b24;
    int   ts;
    int   tm;
    int   th;
    logic cs_co;
    logic ch_co;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  int m60 = 0;
  int m24 = 0;
  int ms  = 0;
  int mm  = 0;
  int mh  = 0;

  function automatic int nxt(int v, int md, logic r,
                             logic a, logic s, logic h);
    if (!r) return 0;
    if (h) return v;
    if (a && !s) return (v + 1) % md;
    if (s && !a) return (v + md - 1) % md;
    return v;
  endfunction

  function automatic logic car(int v, int md, logic r,
                               logic a, logic s, logic h);
    return r && !h && a && !s && (v == md - 1);
  endfunction

  function automatic logic bor(int v, logic r,
                               logic a, logic s, logic h);
    return r && !h && s && !a && (v == 0);
  endfunction

  function automatic logic [7:0] bcd8(int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r,
                       input logic a6, input logic s6, input logic h6,
                       input logic a2, input logic s2, input logic h2,
                       input logic ca_i, input logic cs_i);
    exp_t e;
    logic sc, mc;
    @(posedge clk);
    #1;
    rst        = r;
    bus60.add  = a6;
    bus60.sub  = s6;
    bus60.hold = h6;
    bus24.add  = a2;
    bus24.sub  = s2;
    bus24.hold = h2;
    ca         = ca_i;
    cs         = cs_i;
    e.c60  = car(m60, 60, r, a6, s6, h6);
    e.c24  = car(m24, 24, r, a2, s2, h2);
    e.b60  = bor(m60, r, a6, s6, h6);
    e.b24  = bor(m24, r, a2, s2, h2);
    sc     = car(ms, 60, r, ca_i, cs_i, 1'b0);
    mc     = car(mm, 60, r, sc, cs_i, 1'b0);
    e.cs_co = sc;
    e.ch_co = car(mh, 24, r, mc, cs_i, 1'b0);
    m60 = nxt(m60, 60, r, a6, s6, h6);
    m24 = nxt(m24, 24, r, a2, s2, h2);
    mh  = nxt(mh, 24, r, mc, cs_i, 1'b0);
    mm  = nxt(mm, 60, r, sc, cs_i, 1'b0);
    ms  = nxt(ms, 60, r, ca_i, cs_i, 1'b0);
    e.v60 = m60;
    e.v24 = m24;
    e.ts  = ms;
    e.tm  = mm;
    e.th  = mh;
    q.push_back(e);
  endtask

  task automatic all(input logic r, input logic a,
                     input logic s, input logic h);
    drive(r, a, s, h, a, s, h, 1'b0, 1'b0);
  endtask

  // Monitor: combinational carries mid-cycle, counts after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q[0];
        chk("cout60", 32'(bus60.cout), 32'(e.c60));
        chk("cout24", 32'(bus24.cout), 32'(e.c24));
        chk("cout_sec", 32'(s_co), 32'(e.cs_co));
        chk("cout_hr", 32'(h_co), 32'(e.ch_co));
`ifdef REGISTER_DECIMAL_BORROW_EN
        chk("bout60", 32'(bus60.bout), 32'(e.b60));
        chk("bout24", 32'(bus24.bout), 32'(e.b24));
`endif
        @(posedge clk);
        #2;
        chk("val60", 32'({bus60.high, bus60.low}),
            32'(bcd8(e.v60)));
        chk("val24", 32'({bus24.high, bus24.low}),
            32'(bcd8(e.v24)));
        chk("sec", 32'({s_hi, s_lo}), 32'(bcd8(e.ts)));
        chk("min", 32'({m_hi, m_lo}), 32'(bcd8(e.tm)));
        chk("hr", 32'({h_hi, h_lo}), 32'(bcd8(e.th)));
        void'(q.pop_front());
      end
    end
  end

  initial begin
    bus60.add  = 1'b0;
    bus60.sub  = 1'b0;
    bus60.hold = 1'b0;
    bus24.add  = 1'b0;
    bus24.sub  = 1'b0;
    bus24.hold = 1'b0;

    all(1, 0, 0, 1);
    all(0, 1, 1, 1);
    repeat (60) all(1, 1, 0, 0);
    repeat (51) all(1, 0, 1, 0);

    all(0, 0, 0, 0);
    repeat (37) all(1, 1, 0, 0);
    all(1, 1, 1, 0);
    all(1, 1, 0, 1);
    repeat (22) all(1, 1, 0, 0);
    all(1, 1, 0, 1);

    all(0, 0, 0, 0);
    repeat (42) all(1, 1, 0, 0);
    all(0, 1, 0, 0);
    all(1, 1, 0, 0);

    all(0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);

    repeat (3000) begin
      drive($urandom_range(0, 49) != 0,
            ($urandom % 4) != 0, ($urandom % 4) == 0,
            ($urandom % 8) == 0,
            ($urandom % 4) != 0, ($urandom % 4) == 0,
            ($urandom % 8) == 0,
            ($urandom % 8) != 0, ($urandom % 64) == 0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/register_decimal.md
REGISTER_DECIMAL -- requirements
Module: register_decimal

Interface
REQ-001 SHALL have parameter: MODULUS, default 60, count modulus (legal range 2..99; 24 = hours, 60 = minutes/seconds).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low; callers not using reset tie it to 1.
REQ-004 SHALL have port: add  input  1  level-sampled increment request, one step per clk edge while high.
REQ-005 SHALL have port: sub  input  1  level-sampled decrement request, one step per clk edge while high.
REQ-006 SHALL have port: hold  input  1  freeze; blocks add and sub.
REQ-007 SHALL have port: low  output  4  BCD units digit of the count.
REQ-008 SHALL have port: high  output  4  BCD tens digit of the count.
REQ-009 SHALL have port: cout  output  1  carry out, used to cascade into the next register's add.

Function
REQ-010 SHALL hold the count internally as two BCD digits; value = 10*high + low, always 0..MODULUS-1, each digit 0..9.
REQ-011 SHALL apply this priority at each clk edge: rst low, then hold high, then add/sub.
REQ-012 SHALL, with hold=0, add=1, sub=0: increment by 1; units 9 -> 0 carries to tens; MODULUS-1 wraps to 00 (59->00, 23->00).
REQ-013 SHALL, with hold=0, add=0, sub=1: decrement by 1; units 0 -> 9 borrows from tens; 00 wraps to MODULUS-1 (00->59, 00->23).
REQ-014 SHALL leave the count unchanged when add and sub are both high, both low, or hold is high.
REQ-015 SHALL drive cout combinationally = add & ~sub & ~hold & rst & (count == MODULUS-1).
REQ-016 SHALL make cout high in the same cycle the wrap edge occurs, so a cascaded register fed from cout steps on the same edge (59:59 -> 00:00 in one edge).
REQ-017 SHALL drive cout low during decrements, including the 00 -> MODULUS-1 wrap.
REQ-018 SHALL drive low/high directly from the registers, with no added output latency; a change is visible right after the edge.

Reset
REQ-019 SHALL, on a clk edge with rst=0, load 00 regardless of add, sub and hold.
REQ-020 SHALL force cout to 0 while rst=0.
REQ-021 SHALL resume counting from 00 on the first edge after rst returns high.
REQ-022 SHALL initialize the count to 00 at power-up (simulation initial value) so the count is defined before any reset.

Configuration
REQ-023 SHALL, with macro REGISTER_DECIMAL_BORROW_EN defined, add output port bout (1 bit), combinationally = sub & ~add & ~hold & rst & (count == 0).
REQ-024 SHALL, with REGISTER_DECIMAL_BORROW_EN undefined, omit the bout port; all other behaviour is identical.

Structure
REQ-025 SHALL place in shared package register_decimal_pkg: the 4-bit BCD digit typedef and constants MOD_HOURS=24 and MOD_MINSEC=60.
REQ-026 SHALL provide thin wrappers register24_decimal (MODULUS=MOD_HOURS) and register60_decimal (MODULUS=MOD_MINSEC), each with the identical port list.
REQ-027 SHALL use no sub-module beyond the wrappers; the digit logic stays inline.
REQ-028 SHALL reject at elaboration any MODULUS outside 2..99.

Verification
REQ-029 SHALL cover: MODULUS=60, reset, add=1 for 60 edges -> 00,01..09,10..59,00; cout high only during the 59 cycle.
REQ-030 SHALL cover: MODULUS=24 at 23, add=1 one edge -> 00, cout=1 before the edge; at 09, add -> 10.
REQ-031 SHALL cover: MODULUS=60 at 00, sub=1 -> 59, cout=0; at 10, sub -> 09; with BORROW_EN, bout=1 at 00.
REQ-032 SHALL cover: count 37, add=sub=1, or hold=1 with add=1 -> stays 37; hold=1 at 59 with add -> cout=0.
REQ-033 SHALL cover: count 42 with add=1, rst=0 for one edge -> 00; next edge with rst=1 and add=1 -> 01.
REQ-034 SHALL cover: cascade of register60_decimal (sec) -> register60_decimal (min) -> register24_decimal (hr) at 23:59:59, add=1 one edge -> 00:00:00.
